// File: rtl/alu_decode_stage.sv
// Decode/operand-issue stage for RV32I ALU ops with a one-entry skid buffer.
// Optional writeback forwarding/snooping is enabled by defining ALU_DECODE_FWD_EN.
`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_AND  4'd2
`define ALU_OR   4'd3
`define ALU_XOR  4'd4
`define ALU_ADDI 4'd5
`define ALU_SLLI 4'd6
`define ALU_SRLI 4'd7
`define ALU_SRAI 4'd8
`endif

module alu_decode_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic [XLEN-1:0]   rf_rdata2,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ex_rs1,
    output logic [XLEN-1:0]   ex_rs2,
    output logic [3:0]        ex_alu_op,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_wen,
    output logic              ex_illegal
);

    typedef struct packed {
        logic [XLEN-1:0]   rs1;
        logic [XLEN-1:0]   rs2;
        logic [3:0]        alu_op;
        logic [REG_AW-1:0] rd;
        logic              wen;
        logic              illegal;
        logic              rs1_is_reg;
        logic              rs2_is_reg;
        logic [REG_AW-1:0] rs1_idx;
        logic [REG_AW-1:0] rs2_idx;
    } entry_t;

    entry_t out_reg, skid_reg, dec_entry, new_entry, out_fwd, skid_fwd;
    logic   ex_valid_reg, skid_valid_reg;
    logic   accept, out_load;

    logic [6:0]        opcode, funct7;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rs1_idx, rs2_idx, rd_idx;
    logic [XLEN-1:0]   rs1_val, rs2_val;
    logic              legal, r_type, is_addi;
    logic [3:0]        op_next;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign rd_idx    = instr[11:7];
    assign rs1_idx   = instr[19:15];
    assign rs2_idx   = instr[24:20];
    assign rf_raddr1 = rs1_idx;
    assign rf_raddr2 = rs2_idx;
    assign rs1_val   = (rs1_idx == '0) ? '0 : rf_rdata1;
    assign rs2_val   = (rs2_idx == '0) ? '0 : rf_rdata2;

    always_comb begin
        legal   = 1'b1;
        r_type  = 1'b0;
        is_addi = 1'b0;
        op_next = `ALU_ADD;
        case (opcode)
            7'b0110011: begin
                r_type = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'b000}: op_next = `ALU_ADD;
                    {7'h20, 3'b000}: op_next = `ALU_SUB;
                    {7'h00, 3'b111}: op_next = `ALU_AND;
                    {7'h00, 3'b110}: op_next = `ALU_OR;
                    {7'h00, 3'b100}: op_next = `ALU_XOR;
                    default:         legal   = 1'b0;
                endcase
            end
            7'b0010011: begin
                // ADDI ignores funct7 since those bits belong to its immediate
                if (funct3 == 3'b000) begin
                    is_addi = 1'b1;
                    op_next = `ALU_ADDI;
                end else if (funct3 == 3'b001 && funct7 == 7'h00) op_next = `ALU_SLLI;
                else if (funct3 == 3'b101 && funct7 == 7'h00)     op_next = `ALU_SRLI;
                else if (funct3 == 3'b101 && funct7 == 7'h20)     op_next = `ALU_SRAI;
                else                                              legal   = 1'b0;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        dec_entry         = '0;
        dec_entry.alu_op  = legal ? op_next : `ALU_ADD;
        dec_entry.rd      = rd_idx;
        dec_entry.wen     = legal && (rd_idx != '0);
        dec_entry.illegal = !legal;
        if (legal) begin
            dec_entry.rs1        = rs1_val;
            dec_entry.rs1_is_reg = 1'b1;
            dec_entry.rs1_idx    = rs1_idx;
            if (r_type) begin
                dec_entry.rs2        = rs2_val;
                dec_entry.rs2_is_reg = 1'b1;
                dec_entry.rs2_idx    = rs2_idx;
            end else if (is_addi) begin
                dec_entry.rs2 = {{(XLEN-12){instr[31]}}, instr[31:20]};
            end else begin
                dec_entry.rs2 = {{(XLEN-5){1'b0}}, instr[24:20]};
            end
        end
    end

`ifdef ALU_DECODE_FWD_EN
    // Replace register-sourced operands whose source matches the writeback bus
    function automatic entry_t snoop(input entry_t e, input logic v,
                                     input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] d);
        entry_t r;
        r = e;
        if (v && rd != '0) begin
            if (e.rs1_is_reg && e.rs1_idx == rd) r.rs1 = d;
            if (e.rs2_is_reg && e.rs2_idx == rd) r.rs2 = d;
        end
        return r;
    endfunction

    assign new_entry = snoop(dec_entry, wb_valid, wb_rd, wb_data);
    assign out_fwd   = snoop(out_reg,   wb_valid, wb_rd, wb_data);
    assign skid_fwd  = snoop(skid_reg,  wb_valid, wb_rd, wb_data);
`else
    logic unused_fwd;
    assign unused_fwd = ^{wb_valid, wb_rd, wb_data, out_reg.rs1_is_reg, out_reg.rs2_is_reg,
                          out_reg.rs1_idx, out_reg.rs2_idx};
    assign new_entry = dec_entry;
    assign out_fwd   = out_reg;
    assign skid_fwd  = skid_reg;
`endif

    assign instr_ready = !skid_valid_reg;
    assign accept      = instr_valid && instr_ready;
    assign out_load    = !ex_valid_reg || ex_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg        <= '0;
            out_reg.alu_op <= `ALU_ADD;
            skid_reg       <= '0;
            ex_valid_reg   <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else begin
            if (out_load) begin
                if (skid_valid_reg) begin
                    out_reg        <= skid_fwd;
                    ex_valid_reg   <= 1'b1;
                    skid_valid_reg <= 1'b0;
                end else if (accept) begin
                    out_reg      <= new_entry;
                    ex_valid_reg <= 1'b1;
                end else begin
                    ex_valid_reg <= 1'b0;
                end
            end else begin
                out_reg <= out_fwd;
                // accept implies the skid is empty, so the two branches never collide
                if (accept) begin
                    skid_reg       <= new_entry;
                    skid_valid_reg <= 1'b1;
                end else if (skid_valid_reg) begin
                    skid_reg <= skid_fwd;
                end
            end
        end
    end

    assign ex_valid   = ex_valid_reg;
    assign ex_rs1     = out_reg.rs1;
    assign ex_rs2     = out_reg.rs2;
    assign ex_alu_op  = out_reg.alu_op;
    assign ex_rd      = out_reg.rd;
    assign ex_wen     = out_reg.wen;
    assign ex_illegal = out_reg.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed self-checking bench for alu_decode_stage; register file is a small
// behavioural array with x0 deliberately non-zero to exercise the x0 override.
`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_AND  4'd2
`define ALU_OR   4'd3
`define ALU_XOR  4'd4
`define ALU_ADDI 4'd5
`define ALU_SLLI 4'd6
`define ALU_SRLI 4'd7
`define ALU_SRAI 4'd8
`endif

module tb_alu_decode_stage;
    logic        clk = 1'b0;
    logic        rst, instr_valid, instr_ready, wb_valid, ex_valid, ex_ready;
    logic        ex_wen, ex_illegal;
    logic [31:0] instr, rf_rdata1, rf_rdata2, wb_data, ex_rs1, ex_rs2;
    logic [4:0]  rf_raddr1, rf_raddr2, wb_rd, ex_rd;
    logic [3:0]  ex_alu_op;
    logic [31:0] rf [32];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    alu_decode_stage dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
        .ex_wen(ex_wen), .ex_illegal(ex_illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_entry(input string tag, input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [3:0] op, input logic [4:0] rd, input logic wen,
                               input logic ill);
        check({tag, ".valid"}, {31'd0, ex_valid}, 32'd1);
        check({tag, ".rs1"}, ex_rs1, rs1);
        check({tag, ".rs2"}, ex_rs2, rs2);
        check({tag, ".op"}, {28'd0, ex_alu_op}, {28'd0, op});
        check({tag, ".rd"}, {27'd0, ex_rd}, {27'd0, rd});
        check({tag, ".wen"}, {31'd0, ex_wen}, {31'd0, wen});
        check({tag, ".illegal"}, {31'd0, ex_illegal}, {31'd0, ill});
        $display("[TB] %s rs1=%h rs2=%h op=%0d rd=%0d wen=%0b ill=%0b",
                 tag, ex_rs1, ex_rs2, ex_alu_op, ex_rd, ex_wen, ex_illegal);
    endtask

    typedef struct {
        string       name;
        logic [31:0] word;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  op;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs [7];
    logic [31:0] exp_rs1;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
        rf[0] = 32'hDEAD_BEEF;
        rf[1] = 32'd5;
        rf[2] = 32'd7;

        vecs[0] = '{"ADD",  32'h002081B3, 32'd5, 32'd7,          `ALU_ADD,  5'd3};
        vecs[1] = '{"ADDI", 32'hFFF00213, 32'd0, 32'hFFFF_FFFF,  `ALU_ADDI, 5'd4};
        vecs[2] = '{"SRAI", 32'h4030D293, 32'd5, 32'd3,          `ALU_SRAI, 5'd5};
        vecs[3] = '{"SUB",  32'h40208333, 32'd5, 32'd7,          `ALU_SUB,  5'd6};
        vecs[4] = '{"AND",  32'h0020F3B3, 32'd5, 32'd7,          `ALU_AND,  5'd7};
        vecs[5] = '{"SLLI", 32'h00409413, 32'd5, 32'd4,          `ALU_SLLI, 5'd8};
        vecs[6] = '{"SRLI", 32'h01F15493, 32'd7, 32'd31,         `ALU_SRLI, 5'd9};

        rst = 1'b1; instr_valid = 1'b0; instr = '0; ex_ready = 1'b1;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset.valid", {31'd0, ex_valid}, 32'd0);
        check("reset.ready", {31'd0, instr_ready}, 32'd1);
        check("reset.op", {28'd0, ex_alu_op}, {28'd0, `ALU_ADD});
        check("reset.wen", {31'd0, ex_wen}, 32'd0);
        check("reset.rs1", ex_rs1, 32'd0);
        check("reset.illegal", {31'd0, ex_illegal}, 32'd0);

        // Back-to-back legal words with the ALU always ready
        instr_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            instr = vecs[i].word;
            tick();
            check_entry(vecs[i].name, vecs[i].rs1, vecs[i].rs2, vecs[i].op, vecs[i].rd, 1'b1, 1'b0);
        end
        instr_valid = 1'b0;
        tick();
        check("drain.valid", {31'd0, ex_valid}, 32'd0);

        // Backpressure: output holds AND, skid holds OR, XOR waits upstream
        ex_ready = 1'b0;
        instr_valid = 1'b1;
        instr = 32'h0020F3B3;
        tick();
        instr = 32'h0020E3B3;
        tick();
        instr = 32'h0020C3B3;
        tick();
        check("bp.ready_low", {31'd0, instr_ready}, 32'd0);
        check_entry("bp.held", 32'd5, 32'd7, `ALU_AND, 5'd7, 1'b1, 1'b0);
        ex_ready = 1'b1;
        tick();
        check_entry("bp.second", 32'd5, 32'd7, `ALU_OR, 5'd7, 1'b1, 1'b0);
        check("bp.ready_high", {31'd0, instr_ready}, 32'd1);
        tick();
        check_entry("bp.third", 32'd5, 32'd7, `ALU_XOR, 5'd7, 1'b1, 1'b0);
        instr_valid = 1'b0;
        tick();
        check("bp.empty", {31'd0, ex_valid}, 32'd0);

        // Writeback snoop on a held entry
        ex_ready = 1'b0;
        instr_valid = 1'b1;
        instr = 32'h40208333;
        tick();
        instr_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h55;
        tick();
`ifdef ALU_DECODE_FWD_EN
        exp_rs1 = 32'h55;
`else
        exp_rs1 = 32'd5;
`endif
        check_entry("fwd.match", exp_rs1, 32'd7, `ALU_SUB, 5'd6, 1'b1, 1'b0);
        wb_rd = 5'd0; wb_data = 32'h99;
        tick();
        check_entry("fwd.x0", exp_rs1, 32'd7, `ALU_SUB, 5'd6, 1'b1, 1'b0);
        wb_valid = 1'b0;
        ex_ready = 1'b1;
        tick();

        // Illegal word and rd=x0
        instr_valid = 1'b1;
        instr = 32'h0000007F;
        tick();
        check_entry("illegal", 32'd0, 32'd0, `ALU_ADD, 5'd0, 1'b0, 1'b1);
        instr = 32'h00208033;
        tick();
        check_entry("add_x0", 32'd5, 32'd7, `ALU_ADD, 5'd0, 1'b0, 1'b0);

        // Mid-operation reset drops both output and skid entries
        ex_ready = 1'b0;
        instr = 32'h002081B3;
        tick();
        tick();
        check("pre_rst.ready", {31'd0, instr_ready}, 32'd0);
        instr_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst.valid", {31'd0, ex_valid}, 32'd0);
        check("mid_rst.ready", {31'd0, instr_ready}, 32'd1);
        check("mid_rst.rd", {27'd0, ex_rd}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
